// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin junction controller with tick-timed green/amber/clear and pedestrian walk insertion
module traffic_phase_ctrl #(
    parameter int N_PHASES    = 2,
    parameter int CNT_W       = 4,
    parameter int GREEN_T     = 6,
    parameter int MIN_GREEN_T = 3,
    parameter int AMBER_T     = 3,
    parameter int CLEAR_T     = 1,
    parameter int WALK_T      = 8,
    localparam int PH_W       = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_i,
    input  logic                  ped_i,
    output logic [2*N_PHASES-1:0] lights_o,
    output logic                  walk_o,
    output logic                  ped_pending_o,
    output logic [PH_W-1:0]       phase_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      count_o
);
    typedef enum logic [1:0] {GREEN = 2'b00, AMBER = 2'b01, CLEAR = 2'b10, WALK = 2'b11} state_e;

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(AMBER_T - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CLEAR_T - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_T - 1);
    // one bit wider than phase so an out-of-range phase is detectable for any N
    localparam logic [PH_W:0]    PH_MAX  = (PH_W + 1)'(N_PHASES - 1);

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    pend_q, pend_d;
    logic [2*N_PHASES-1:0]   lights_q, lights_d;
    logic                    walk_q, walk_d;
    logic                    last;

    // next state, counter, pending latch and lamp decode for the registered outputs
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        count_d  = count_q;
        lights_d = '0;
        last     = 1'b0;
        case (state_q)
            GREEN:   last = (count_q == G_LAST) || (pend_q && count_q >= MG_LAST);
            AMBER:   last = count_q == A_LAST;
            CLEAR:   last = count_q == C_LAST;
            default: last = count_q == W_LAST;
        endcase
        if (tick_i) count_d = count_q + CNT_W'(1);
        if (tick_i && last) begin
            count_d = '0;
            case (state_q)
                GREEN:   state_d = AMBER;
                AMBER:   state_d = pend_q ? WALK : CLEAR;
                CLEAR: begin
                    state_d = GREEN;
                    phase_d = ({1'b0, phase_q} == PH_MAX) ? '0 : phase_q + PH_W'(1);
                end
                default: state_d = CLEAR;
            endcase
        end
        if ({1'b0, phase_q} > PH_MAX) begin
            state_d = CLEAR;
            phase_d = PH_MAX[PH_W-1:0];
            count_d = '0;
        end
        // a request seen while walking, or on the walk entry edge, is already being served
        pend_d = (state_q == WALK || state_d == WALK) ? 1'b0 : (pend_q | ped_i);
        for (int i = 0; i < N_PHASES; i++)
            lights_d[2*i +: 2] = (phase_d != PH_W'(i)) ? 2'b00 :
                                 (state_d == GREEN)    ? 2'b10 :
                                 (state_d == AMBER)    ? 2'b01 : 2'b00;
        walk_d = state_d == WALK;
    end

    // state and output registers, async reset parks the junction in all-red before phase 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CLEAR;
            phase_q  <= PH_MAX[PH_W-1:0];
            count_q  <= '0;
            pend_q   <= 1'b0;
            lights_q <= '0;
            walk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            lights_q <= lights_d;
            walk_q   <= walk_d;
        end
    end

    assign lights_o      = lights_q;
    assign walk_o        = walk_q;
    assign ped_pending_o = pend_q;
    assign phase_o       = phase_q;
    assign state_o       = state_q;
    assign count_o       = count_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed scenarios on a 2-approach and a 3-approach controller with a cycle scoreboard
module tb_traffic_phase_ctrl;
    logic clk = 1'b0, rst_n = 1'b1, tick = 1'b0, ped = 1'b0;
    logic [3:0] a_lt; logic a_wk, a_pd; logic [0:0] a_ph; logic [1:0] a_st; logic [3:0] a_ct;
    logic [5:0] b_lt; logic b_wk, b_pd; logic [1:0] b_ph; logic [1:0] b_st; logic [4:0] b_ct;
    int n_vec = 0, n_err = 0;

    typedef struct {int st; int ph; int cnt; bit pend;} mdl_t;
    typedef struct {int n; int g; int mg; int a; int c; int w;} prm_t;
    typedef struct {mdl_t a; mdl_t b;} exp_t;
    exp_t exp_q[$];
    mdl_t ma, mb;
    prm_t pa_p, pb_p;

    always #5 clk = ~clk;

    traffic_phase_ctrl dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .ped_i(ped),
        .lights_o(a_lt), .walk_o(a_wk), .ped_pending_o(a_pd),
        .phase_o(a_ph), .state_o(a_st), .count_o(a_ct)
    );

    traffic_phase_ctrl #(.N_PHASES(3), .CNT_W(5), .WALK_T(20)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .ped_i(ped),
        .lights_o(b_lt), .walk_o(b_wk), .ped_pending_o(b_pd),
        .phase_o(b_ph), .state_o(b_st), .count_o(b_ct)
    );

    task automatic chk(input string tag, input int got, input int expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // reference behaviour: how one clock edge moves the junction, written from the phase timing rules
    function automatic mdl_t nxt(mdl_t m, prm_t p, bit tk, bit pd);
        mdl_t r = m;
        int dur = (m.st == 0) ? p.g : (m.st == 1) ? p.a : (m.st == 2) ? p.c : p.w;
        bit go = tk && (m.cnt == dur - 1 || (m.st == 0 && m.pend && m.cnt >= p.mg - 1));
        if (tk) r.cnt = m.cnt + 1;
        if (go) begin
            r.cnt = 0;
            if (m.st == 0) r.st = 1;
            else if (m.st == 1) r.st = m.pend ? 3 : 2;
            else if (m.st == 3) r.st = 2;
            else begin r.st = 0; r.ph = (m.ph + 1) % p.n; end
        end
        r.pend = (m.st == 3 || r.st == 3) ? 1'b0 : (m.pend | pd);
        return r;
    endfunction

    function automatic int lexp(mdl_t m, int n);
        int v = 0;
        for (int i = 0; i < n; i++)
            if (m.ph == i) v = (m.st == 0) ? (2 << (2 * i)) : (m.st == 1) ? (1 << (2 * i)) : 0;
        return v;
    endfunction

    task automatic cmp(input string t, input mdl_t m, input int n, input int st, input int ph,
                       input int ct, input int pd, input int wk, input int lt);
        chk({t, ".state"}, st, m.st);
        chk({t, ".phase"}, ph, m.ph);
        chk({t, ".count"}, ct, m.cnt);
        chk({t, ".pending"}, pd, int'(m.pend));
        chk({t, ".walk"}, wk, (m.st == 3) ? 1 : 0);
        chk({t, ".lights"}, lt, lexp(m, n));
    endtask

    // one clock: drive inputs, queue the predicted outputs, then check them after the edge
    task automatic cyc(input bit tk, input bit pd);
        exp_t e;
        tick = tk; ped = pd;
        ma = nxt(ma, pa_p, tk, pd);
        mb = nxt(mb, pb_p, tk, pd);
        e.a = ma; e.b = mb;
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        cmp("A", e.a, 2, a_st, a_ph, a_ct, a_pd, a_wk, a_lt);
        cmp("B", e.b, 3, b_st, b_ph, b_ct, b_pd, b_wk, b_lt);
        tick = 1'b0; ped = 1'b0;
    endtask

    task automatic tk4(input int n, input bit hold);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, hold); cyc(1'b0, hold); cyc(1'b0, hold); cyc(1'b0, hold);
        end
    endtask

    // asserts reset between clock edges and checks the outputs fall back without waiting for a clock
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.a.state", a_st, 2); chk("rst.a.phase", a_ph, 1); chk("rst.a.count", a_ct, 0);
        chk("rst.a.lights", a_lt, 0); chk("rst.a.walk", a_wk, 0); chk("rst.a.pending", a_pd, 0);
        chk("rst.b.state", b_st, 2); chk("rst.b.phase", b_ph, 2); chk("rst.b.pending", b_pd, 0);
        ma = '{st: 2, ph: 1, cnt: 0, pend: 1'b0};
        mb = '{st: 2, ph: 2, cnt: 0, pend: 1'b0};
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic inv(input string t, input int lt, input bit wk, input int n);
        int nr = 0, bad = 0;
        for (int i = 0; i < n; i++) begin
            if (((lt >> (2 * i)) & 3) != 0) nr++;
            if (((lt >> (2 * i)) & 3) == 3) bad = 1;
        end
        if (nr > 1 || (wk && lt != 0)) bad = 1;
        chk(t, bad, 0);
    endtask

    // safety: never two approaches non-red, never walk with a lamp lit
    always @(negedge clk) if (rst_n) begin
        inv("inv.a", int'(a_lt), a_wk, 2);
        inv("inv.b", int'(b_lt), b_wk, 3);
    end

    initial begin
        pa_p = '{n: 2, g: 6, mg: 3, a: 3, c: 1, w: 8};
        pb_p = '{n: 3, g: 6, mg: 3, a: 3, c: 1, w: 20};
        do_reset();
        // plain rotation with no pedestrians
        tk4(1, 0); chk("s1.g0.state", a_st, 0); chk("s1.g0.phase", a_ph, 0);
        tk4(5, 0); chk("s1.g0.state5", a_st, 0); chk("s1.g0.count", a_ct, 5);
        tk4(1, 0); chk("s1.a0.state", a_st, 1);
        tk4(3, 0); chk("s1.clr.state", a_st, 2); chk("s1.clr.phase", a_ph, 0);
        tk4(1, 0); chk("s1.g1.state", a_st, 0); chk("s1.g1.phase", a_ph, 1);
        tk4(9, 0); chk("s1.clr1.state", a_st, 2);
        tk4(1, 0); chk("s1.wrap.state", a_st, 0); chk("s1.wrap.phase", a_ph, 0);
        chk("s6.b.phase2", b_ph, 2);
        // pedestrian pulse early in green: green cut at minimum, then walk
        tk4(1, 0); cyc(1'b0, 1'b1); chk("s2.pending", a_pd, 1); cyc(1'b0, 1'b0);
        tk4(1, 0); chk("s2.g0.state", a_st, 0); chk("s2.g0.count", a_ct, 2);
        tk4(1, 0); chk("s2.cut", a_st, 1);
        tk4(3, 0); chk("s2.walk.state", a_st, 3); chk("s2.walk.walk", a_wk, 1);
        chk("s2.walk.pending", a_pd, 0); chk("s2.walk.lights", a_lt, 0);
        tk4(7, 0); chk("s2.walk7.state", a_st, 3); chk("s2.walk7.count", a_ct, 7);
        tk4(1, 0); chk("s2.clr.state", a_st, 2); chk("s6.b.walk", b_st, 3); chk("s6.b.walkcnt", b_ct, 8);
        tk4(1, 0); chk("s2.g1.state", a_st, 0); chk("s2.g1.phase", a_ph, 1);
        // request past minimum green ends green on the next tick; request during amber adds walk
        tk4(4, 0); cyc(1'b0, 1'b1);
        tk4(1, 0); chk("s3.late.state", a_st, 1); chk("s3.late.phase", a_ph, 1);
        tk4(3, 0); chk("s3.late.walk", a_st, 3);
        tk4(8, 0); chk("s3.clr", a_st, 2);
        tk4(1, 0); chk("s3.g0.state", a_st, 0); chk("s3.g0.pending", a_pd, 0);
        tk4(6, 0); chk("s3.amber", a_st, 1); chk("s3.amber.pending", a_pd, 0);
        cyc(1'b0, 1'b1); chk("s3.amber.req", a_pd, 1);
        tk4(3, 0); chk("s3.amber.walk", a_st, 3); chk("s3.amber.served", a_pd, 0);
        // button held through the whole walk latches only once walk is over
        tk4(7, 1); chk("s4.hold.state", a_st, 3); chk("s4.hold.pending", a_pd, 0);
        tk4(1, 1); chk("s4.clr.state", a_st, 2); chk("s4.clr.pending", a_pd, 1);
        tk4(1, 0); chk("s4.g1.state", a_st, 0); chk("s4.g1.phase", a_ph, 1);
        tk4(2, 0); chk("s4.g1.count", a_ct, 2);
        tk4(1, 0); chk("s4.cut", a_st, 1);
        tk4(3, 0); chk("s4.walk", a_st, 3);
        // asynchronous reset mid-walk, then reset discarding a pending request
        tk4(2, 0); chk("s5.inwalk", a_st, 3);
        do_reset();
        tk4(1, 0); cyc(1'b0, 1'b1); chk("s5.pending", a_pd, 1);
        do_reset();
        tk4(1, 0); chk("s5.g0.state", a_st, 0); chk("s5.g0.pending", a_pd, 0);
        // three approaches with a long walk
        cyc(1'b0, 1'b1); chk("s6.b.pending", b_pd, 1);
        tk4(3, 0); chk("s6.b.amber", b_st, 1);
        tk4(3, 0); chk("s6.b.walk20", b_st, 3);
        tk4(19, 0); chk("s6.b.walk19", b_st, 3); chk("s6.b.walk19cnt", b_ct, 19);
        tk4(1, 0); chk("s6.b.clr", b_st, 2);
        tk4(1, 0); chk("s6.b.g1", b_st, 0); chk("s6.b.g1phase", b_ph, 1);
        tk4(10, 0); chk("s6.b.g2phase", b_ph, 2);
        tk4(10, 0); chk("s6.b.g0phase", b_ph, 0); chk("s6.b.g0state", b_st, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
